// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Arbitrates the single register-file write port between the pipeline
// writeback (WB) and the multicycle mul/div unit (MD).  After reset it
// first clears x1..x31 (INIT), then grants the port each cycle (RUN).
// WB has priority unless MD has been denied STARVE_LIMIT cycles in a row.
// A 32-bit pending scoreboard tracks destinations of issued MD operations
// so decode can detect sources that are still waiting on an MD result.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_we, wb_rd, wb_data         writeback request, destination, data
//   wb_stall                      writeback not accepted this cycle
//   md_valid, md_rd, md_data      MD result request, destination, data
//   md_ready                      MD result accepted this cycle
//   md_issue, md_issue_rd         MD op issued, destination to mark pending
//   rs1, rs2, pend_rs1, pend_rs2  decode sources and their pending flags
//   init_busy                     register-clear sequence in progress
//   WE3, A3, WD3                  register-file write port (combinational)
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        pend_rs1,
  output logic        pend_rs2,
  output logic        wb_stall,
  output logic        init_busy,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3
);

  localparam int SW = ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nxt;
  logic [4:0]      cnt, cnt_nxt;
  logic [31:0]     pending, pending_nxt;
  logic [SW-1:0]   starve, starve_nxt;
  logic            force_md;
  logic            md_xfer;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v >= SW'(STARVE_LIMIT)) return v;
    return v + SW'(1);
  endfunction

  assign force_md = md_valid && (starve == SW'(STARVE_LIMIT));
  assign md_xfer  = md_valid && md_ready;

  // Grant / write-port decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    WE3       = 1'b0;
    A3        = 5'd0;
    WD3       = 32'd0;
    md_ready  = 1'b0;
    wb_stall  = 1'b1;
    init_busy = 1'b1;
    if (!rst) begin
      case (state)
        INIT: begin
          WE3 = 1'b1;
          A3  = cnt;
          if (cnt == 5'd31) state_nxt = RUN;
          else              cnt_nxt   = cnt + 5'd1;
        end
        RUN: begin
          init_busy = 1'b0;
          wb_stall  = wb_we && force_md;
          if (force_md || (md_valid && !wb_we)) begin
            md_ready = 1'b1;
            A3       = md_rd;
            WD3      = md_data;
            WE3      = (md_rd != 5'd0);
          end else if (wb_we) begin
            A3  = wb_rd;
            WD3 = wb_data;
            WE3 = (wb_rd != 5'd0);
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  // Scoreboard and starvation bookkeeping; a same-cycle set beats the clear
  always_comb begin
    pending_nxt = pending;
    if (md_xfer) pending_nxt[md_rd] = 1'b0;
    if (state == RUN && md_issue && md_issue_rd != 5'd0)
      pending_nxt[md_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;

    starve_nxt = starve;
    if (!md_valid || md_xfer) starve_nxt = '0;
    else if (state == RUN)    starve_nxt = sat_inc(starve);
  end

  assign pend_rs1 = !rst && (rs1 != 5'd0) && pending[rs1];
  assign pend_rs2 = !rst && (rs2 != 5'd0) && pending[rs2];

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= 5'd1;
      pending <= '0;
      starve  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      starve  <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Directed stimulus for rf_write_arbiter.  The driver pushes the expected
// output vector for each cycle into a queue; an independent monitor pops it
// on the falling edge and compares against the DUT outputs.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic        md_issue = 1'b0;
  logic [4:0]  md_issue_rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        pend_rs1, pend_rs2, wb_stall, init_busy, WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        chk_addr;
    logic        rdy;
    logic        stall;
    logic        busy;
    logic        p1;
    logic        p2;
  } exp_t;

  exp_t q[$];

  rf_write_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .rs1(rs1), .rs2(rs2), .pend_rs1(pend_rs1), .pend_rs2(pend_rs2),
    .wb_stall(wb_stall), .init_busy(init_busy),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic iss, input logic [4:0] ird,
                     input logic [4:0] r1, input logic [4:0] r2);
    wb_we = we; wb_rd = wrd; wb_data = wd;
    md_valid = mv; md_rd = mrd; md_data = md;
    md_issue = iss; md_issue_rd = ird;
    rs1 = r1; rs2 = r2;
  endtask

  task automatic push(input string n, input logic we3, input logic [4:0] a3,
                      input logic [31:0] wd3, input logic chk, input logic rdy,
                      input logic stall, input logic busy, input logic p1, input logic p2);
    exp_t e;
    e.name = n; e.we3 = we3; e.a3 = a3; e.wd3 = wd3; e.chk_addr = chk;
    e.rdy = rdy; e.stall = stall; e.busy = busy; e.p1 = p1; e.p2 = p2;
    q.push_back(e);
  endtask

  // Reset must already be high with an edge still to come; the first edge
  // inside applies it, then rst drops and n clear cycles are checked.
  task automatic run_init(input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      if (i == 1) rst = 1'b0;
      drv(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
      push($sformatf("init%0d", i), 1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic bad;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        bad = (WE3 !== e.we3) || (md_ready !== e.rdy) || (wb_stall !== e.stall) ||
              (init_busy !== e.busy) || (pend_rs1 !== e.p1) || (pend_rs2 !== e.p2);
        if (e.chk_addr && ((A3 !== e.a3) || (WD3 !== e.wd3))) bad = 1'b1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL %s: got we3=%0b a3=%0d wd3=%h rdy=%0b stall=%0b busy=%0b p1=%0b p2=%0b; want we3=%0b a3=%0d wd3=%h rdy=%0b stall=%0b busy=%0b p1=%0b p2=%0b",
                   e.name, WE3, A3, WD3, md_ready, wb_stall, init_busy, pend_rs1, pend_rs2,
                   e.we3, e.a3, e.wd3, e.rdy, e.stall, e.busy, e.p1, e.p2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // Driver
  initial begin
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    step();
    push("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_init(31);

    // WB beats MD, then MD takes the idle port
    step(); drv(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 5'd9, 5'd0);
    push("wb_first", 1'b1, 5'd5, 32'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 5'd0, 5'd0);
    push("md_second", 1'b1, 5'd6, 32'h66, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mark x7 pending
    step(); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    push("issue7", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    push("pend7", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Starvation: three denials, forced grant on the fourth
    step(); drv(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0);
    push("starve1", 1'b1, 5'd1, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); drv(1'b1, 5'd2, 32'h22, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0);
    push("starve2", 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); drv(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0);
    push("starve3", 1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); drv(1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0);
    push("forced_md", 1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); drv(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    push("wb_again", 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Writes to x0
    step(); drv(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    push("wb_x0", 1'b0, 5'd0, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 5'd0, 5'd0);
    push("md_x0", 1'b0, 5'd0, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    push("issue_x0", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Same-cycle set and clear of x12: set wins
    step(); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 5'd12);
    push("issue12", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC, 1'b1, 5'd12, 5'd0, 5'd12);
    push("xfer12", 1'b1, 5'd12, 32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd12);
    push("set_wins", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in RUN with x9 pending, then reset again mid-clear
    step(); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    push("issue9", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    push("pend9", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); rst = 1'b1;
    drv(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 5'd9, 5'd0);
    push("rst_run", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_init(5);
    step(); rst = 1'b1;
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    push("rst_init", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_init(31);
    step(); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    push("run_idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); drv(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    push("run_wb", 1'b1, 5'd9, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    step(); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
